reg_wb_arbiter: RTL and testbench

- Write-side front end of the MIPS register file; the register file itself is the read/responder side.
- Merges writeback results from two producers, the ALU path and the memory-load path, into the file's single write port (RegWrite/Rd/Data).
- Holds one losing result per source, back-pressures each producer with a ready signal, and drives the write port from a registered output stage.
- Optionally exposes bypass lookups so decode can read values that are not yet written.

---
 rtl/reg_wb_arbiter_if.sv | 49 ++++
 rtl/reg_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_reg_wb_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/reg_wb_arbiter_if.sv
// Writeback bus between the ALU/load producers and the register-file write arbiter.
// Forwarding lookup signals exist only when WB_FWD_EN is defined.
interface reg_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_rd;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              RegWrite;
  logic [ADDR_W-1:0] Rd;
  logic [DATA_W-1:0] Data;
  logic              busy;
`ifdef WB_FWD_EN
  logic [ADDR_W-1:0] fwd_ra;
  logic [ADDR_W-1:0] fwd_rb;
  logic              fwd_a_hit;
  logic              fwd_b_hit;
  logic [DATA_W-1:0] fwd_a_data;
  logic [DATA_W-1:0] fwd_b_data;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, fwd_ra, fwd_rb,
    input  alu_ready, mem_ready, RegWrite, Rd, Data, busy,
           fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, fwd_ra, fwd_rb,
    output alu_ready, mem_ready, RegWrite, Rd, Data, busy,
           fwd_a_hit, fwd_b_hit, fwd_a_data, fwd_b_data
  );
`else
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, RegWrite, Rd, Data, busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, RegWrite, Rd, Data, busy
  );
`endif
endinterface

// File: rtl/reg_wb_arbiter.sv
// Merges ALU and load writebacks into the single register-file write port (load wins ties).
// Optional decode bypass lookups are enabled with the WB_FWD_EN macro.
module reg_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  reg_wb_arbiter_if.slave    bus
);

  logic              alu_full_q, alu_full_d;
  logic [ADDR_W-1:0] alu_rd_q, alu_rd_d;
  logic [DATA_W-1:0] alu_data_q, alu_data_d;
  logic              mem_full_q, mem_full_d;
  logic [ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              alu_ready, mem_ready;
  logic              alu_acc, mem_acc;
  logic              alu_head_v, mem_head_v;
  logic [ADDR_W-1:0] alu_head_rd, mem_head_rd;
  logic [DATA_W-1:0] alu_head_data, mem_head_data;
  logic              alu_win, mem_win;

  // A full hold register is always the head; writes to r0 are accepted but never queued.
  always_comb begin
    alu_ready     = rst_n && !alu_full_q;
    mem_ready     = rst_n && !mem_full_q;
    alu_acc       = bus.alu_valid && alu_ready && (bus.alu_rd != '0);
    mem_acc       = bus.mem_valid && mem_ready && (bus.mem_rd != '0);
    alu_head_v    = alu_full_q || alu_acc;
    mem_head_v    = mem_full_q || mem_acc;
    alu_head_rd   = alu_full_q ? alu_rd_q   : bus.alu_rd;
    alu_head_data = alu_full_q ? alu_data_q : bus.alu_data;
    mem_head_rd   = mem_full_q ? mem_rd_q   : bus.mem_rd;
    mem_head_data = mem_full_q ? mem_data_q : bus.mem_data;
    mem_win       = mem_head_v;
    alu_win       = alu_head_v && !mem_head_v;
  end

  always_comb begin
    we_d       = mem_win || alu_win;
    rd_d       = rd_q;
    data_d     = data_q;
    if (mem_win) begin
      rd_d   = mem_head_rd;
      data_d = mem_head_data;
    end else if (alu_win) begin
      rd_d   = alu_head_rd;
      data_d = alu_head_data;
    end
    alu_full_d = alu_head_v && !alu_win;
    alu_rd_d   = alu_full_d ? alu_head_rd   : alu_rd_q;
    alu_data_d = alu_full_d ? alu_head_data : alu_data_q;
    mem_full_d = mem_head_v && !mem_win;
    mem_rd_d   = mem_full_d ? mem_head_rd   : mem_rd_q;
    mem_data_d = mem_full_d ? mem_head_data : mem_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_full_q <= 1'b0;
      alu_rd_q   <= '0;
      alu_data_q <= '0;
      mem_full_q <= 1'b0;
      mem_rd_q   <= '0;
      mem_data_q <= '0;
      we_q       <= 1'b0;
      rd_q       <= '0;
      data_q     <= '0;
    end else begin
      alu_full_q <= alu_full_d;
      alu_rd_q   <= alu_rd_d;
      alu_data_q <= alu_data_d;
      mem_full_q <= mem_full_d;
      mem_rd_q   <= mem_rd_d;
      mem_data_q <= mem_data_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
    end
  end

  assign bus.alu_ready = alu_ready;
  assign bus.mem_ready = mem_ready;
  assign bus.RegWrite  = we_q;
  assign bus.Rd        = rd_q;
  assign bus.Data      = data_q;
  assign bus.busy      = alu_full_q || mem_full_q || we_q;

`ifdef WB_FWD_EN
  // Newest value wins: a held ALU result is younger than a held load, both younger than the output stage.
  always_comb begin
    bus.fwd_a_hit  = 1'b0;
    bus.fwd_a_data = '0;
    if (bus.fwd_ra != '0) begin
      if (alu_full_q && (alu_rd_q == bus.fwd_ra)) begin
        bus.fwd_a_hit  = 1'b1;
        bus.fwd_a_data = alu_data_q;
      end else if (mem_full_q && (mem_rd_q == bus.fwd_ra)) begin
        bus.fwd_a_hit  = 1'b1;
        bus.fwd_a_data = mem_data_q;
      end else if (we_q && (rd_q == bus.fwd_ra)) begin
        bus.fwd_a_hit  = 1'b1;
        bus.fwd_a_data = data_q;
      end
    end
  end

  always_comb begin
    bus.fwd_b_hit  = 1'b0;
    bus.fwd_b_data = '0;
    if (bus.fwd_rb != '0) begin
      if (alu_full_q && (alu_rd_q == bus.fwd_rb)) begin
        bus.fwd_b_hit  = 1'b1;
        bus.fwd_b_data = alu_data_q;
      end else if (mem_full_q && (mem_rd_q == bus.fwd_rb)) begin
        bus.fwd_b_hit  = 1'b1;
        bus.fwd_b_data = mem_data_q;
      end else if (we_q && (rd_q == bus.fwd_rb)) begin
        bus.fwd_b_hit  = 1'b1;
        bus.fwd_b_data = data_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed scenarios then random traffic against a queue model.
// Forwarding checks are compiled only when WB_FWD_EN is defined.
module tb_reg_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
  reg_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

  // Each source queue holds results accepted but not yet written; mem drains first.
  entry_t        aluQ[$];
  entry_t        memQ[$];
  logic          expWrite = 1'b0;
  logic [AW-1:0] expRd = '0;
  logic [DW-1:0] expData = '0;
  int            checks = 0;
  int            errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    aluQ.delete();
    memQ.delete();
    expWrite = 1'b0;
    expRd    = '0;
    expData  = '0;
  endtask

  // One clock of offers; ends #1 after the edge with outputs compared against the model.
  task automatic applyStimulus(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] adata,
                               input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] mdata);
    entry_t e;
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = adata;
    bus.mem_valid = mv;
    bus.mem_rd    = mrd;
    bus.mem_data  = mdata;
    #1;
    checkOutput("alu_ready", {31'b0, bus.alu_ready}, {31'b0, aluQ.size() == 0});
    checkOutput("mem_ready", {31'b0, bus.mem_ready}, {31'b0, memQ.size() == 0});
    if (av && aluQ.size() == 0 && ard != '0) begin
      e.rd = ard; e.data = adata; aluQ.push_back(e);
    end
    if (mv && memQ.size() == 0 && mrd != '0) begin
      e.rd = mrd; e.data = mdata; memQ.push_back(e);
    end
    expWrite = 1'b0;
    if (memQ.size() > 0) begin
      e = memQ.pop_front(); expWrite = 1'b1; expRd = e.rd; expData = e.data;
    end else if (aluQ.size() > 0) begin
      e = aluQ.pop_front(); expWrite = 1'b1; expRd = e.rd; expData = e.data;
    end
    @(posedge clk);
    #1;
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    checkOutput("RegWrite", {31'b0, bus.RegWrite}, {31'b0, expWrite});
    checkOutput("Rd", {27'b0, bus.Rd}, {27'b0, expRd});
    checkOutput("Data", bus.Data, expData);
    checkOutput("busy", {31'b0, bus.busy},
                {31'b0, (aluQ.size() != 0) || (memQ.size() != 0) || expWrite});
  endtask

  initial begin
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
`ifdef WB_FWD_EN
    bus.fwd_ra = '0; bus.fwd_rb = '0;
`endif
    #2;
    checkOutput("rst_RegWrite", {31'b0, bus.RegWrite}, 32'd0);
    checkOutput("rst_Rd", {27'b0, bus.Rd}, 32'd0);
    checkOutput("rst_Data", bus.Data, 32'd0);
    checkOutput("rst_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("rst_alu_ready", {31'b0, bus.alu_ready}, 32'd0);
    checkOutput("rst_mem_ready", {31'b0, bus.mem_ready}, 32'd0);
    #10 rst_n = 1'b1;
    modelReset();
    @(posedge clk);
    #1;

    $display("[TB] single ALU write");
    applyStimulus(1'b1, 5'd1, 32'h1234, 1'b0, 5'd0, 32'h0);
    checkOutput("single_we", {31'b0, bus.RegWrite}, 32'd1);
    checkOutput("single_rd", {27'b0, bus.Rd}, 32'd1);
    checkOutput("single_data", bus.Data, 32'h1234);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("single_we_off", {31'b0, bus.RegWrite}, 32'd0);
    checkOutput("single_busy_off", {31'b0, bus.busy}, 32'd0);

    $display("[TB] collision");
    applyStimulus(1'b1, 5'd3, 32'h3456, 1'b1, 5'd2, 32'h2345);
    checkOutput("coll_rd1", {27'b0, bus.Rd}, 32'd2);
    checkOutput("coll_data1", bus.Data, 32'h2345);
    checkOutput("coll_alu_ready_low", {31'b0, bus.alu_ready}, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("coll_rd2", {27'b0, bus.Rd}, 32'd3);
    checkOutput("coll_data2", bus.Data, 32'h3456);
    checkOutput("coll_alu_ready_high", {31'b0, bus.alu_ready}, 32'd1);

    $display("[TB] same destination");
    applyStimulus(1'b1, 5'd3, 32'h5678, 1'b1, 5'd3, 32'h4567);
    checkOutput("same_data1", bus.Data, 32'h4567);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("same_we2", {31'b0, bus.RegWrite}, 32'd1);
    checkOutput("same_data2", bus.Data, 32'h5678);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("same_final", bus.Data, 32'h5678);

    $display("[TB] zero register");
    applyStimulus(1'b1, 5'd0, 32'h6789, 1'b0, 5'd0, 32'h0);
    checkOutput("zero_we", {31'b0, bus.RegWrite}, 32'd0);
    checkOutput("zero_busy", {31'b0, bus.busy}, 32'd0);
    checkOutput("zero_alu_ready", {31'b0, bus.alu_ready}, 32'd1);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 5'd3, 32'h3456, 1'b1, 5'd2, 32'h2345);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_we", {31'b0, bus.RegWrite}, 32'd0);
    checkOutput("midrst_rd", {27'b0, bus.Rd}, 32'd0);
    checkOutput("midrst_data", bus.Data, 32'd0);
    checkOutput("midrst_alu_ready", {31'b0, bus.alu_ready}, 32'd0);
    checkOutput("midrst_mem_ready", {31'b0, bus.mem_ready}, 32'd0);
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("midrst_no_stale", bus.Data, 32'd0);
    end

    $display("[TB] mem burst starves alu");
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 5'd7, 32'hA1, 1'b1, 5'(8 + i), 32'hB0 + i);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("starve_alu_out", bus.Data, 32'hA1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

`ifdef WB_FWD_EN
    $display("[TB] forwarding");
    bus.fwd_ra = 5'd5;
    bus.fwd_rb = 5'd0;
    applyStimulus(1'b1, 5'd5, 32'h7890, 1'b1, 5'd5, 32'h1111);
    checkOutput("fwd_a_hit_held", {31'b0, bus.fwd_a_hit}, 32'd1);
    checkOutput("fwd_a_data_held", bus.fwd_a_data, 32'h7890);
    checkOutput("fwd_b_hit_zero", {31'b0, bus.fwd_b_hit}, 32'd0);
    checkOutput("fwd_b_data_zero", bus.fwd_b_data, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("fwd_a_hit_out", {31'b0, bus.fwd_a_hit}, 32'd1);
    checkOutput("fwd_a_data_out", bus.fwd_a_data, 32'h7890);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("fwd_a_miss", {31'b0, bus.fwd_a_hit}, 32'd0);
    checkOutput("fwd_a_miss_data", bus.fwd_a_data, 32'd0);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) < 60, 5'($urandom_range(0, 31)), $urandom,
                    $urandom_range(0, 99) < 50, 5'($urandom_range(0, 31)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
